// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: opcodes, states,
// instruction classes and the datapath select codes driven by the controller.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_R, CLS_MUL, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_FENCE, CLS_ECALL,
    CLS_EBREAK, CLS_ILL
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  typedef struct packed {
    logic       src;
    logic [1:0] op;
    logic       a_pc;
  } alu_ctrl_t;

  function automatic alu_ctrl_t alu_ctrl(input cls_t c);
    alu_ctrl_t a;
    a = '{src: 1'b0, op: ALU_ADD, a_pc: 1'b0};
    case (c)
      CLS_R, CLS_MUL:               a.op = ALU_RTYPE;
      CLS_I:                        begin a.src = 1'b1; a.op = ALU_ITYPE; end
      CLS_LOAD, CLS_STORE, CLS_JALR: a.src = 1'b1;
      CLS_AUIPC:                    begin a.src = 1'b1; a.a_pc = 1'b1; end
      CLS_BRANCH:                   a.op = ALU_SUB;
      default:                      ;
    endcase
    return a;
  endfunction

  function automatic logic [1:0] wb_sel_of(input cls_t c);
    case (c)
      CLS_JAL, CLS_JALR: return WB_PC4;
      CLS_LUI:           return WB_IMM;
      CLS_LOAD:          return WB_MEM;
      default:           return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into an instruction class plus a legal flag.
// ebreak/ecall are kept apart so the trap cause stays visible in the class.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic       i_funct7_0,
  input  logic       i_sys_imm0,
  output cls_t       o_cls,
  output logic       o_legal
);

  always_comb begin
    o_cls = CLS_ILL;
    case (i_opcode)
      OP_R:      o_cls = i_funct7_0 ? CLS_MUL : CLS_R;
      OP_I:      o_cls = CLS_I;
      OP_LOAD:   o_cls = CLS_LOAD;
      OP_STORE:  o_cls = CLS_STORE;
      OP_BRANCH: o_cls = CLS_BRANCH;
      OP_JAL:    o_cls = CLS_JAL;
      OP_JALR:   o_cls = CLS_JALR;
      OP_LUI:    o_cls = CLS_LUI;
      OP_AUIPC:  o_cls = CLS_AUIPC;
      OP_FENCE:  o_cls = CLS_FENCE;
      OP_SYSTEM: o_cls = i_sys_imm0 ? CLS_EBREAK : CLS_ECALL;
      default:   o_cls = CLS_ILL;
    endcase
    o_legal = (o_cls != CLS_ILL);
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32IM control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT.
// Outputs decode from the state and the class latched in DECODE; fetch/data waits hold state.
module control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES      = 4,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       funct7_0,
  input  logic       sys_imm0,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       alu_a_pc,
  output logic       mul_busy,
  output logic       halt,
  output logic       illegal,
  output logic [2:0] state
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t    r_state;
  cls_t      r_cls;
  logic [3:0] r_cnt;
  cls_t      w_cls;
  logic      w_legal;
  alu_ctrl_t w_alu;

  ctrl_decode u_decode (
    .i_opcode   (opcode),
    .i_funct7_0 (funct7_0),
    .i_sys_imm0 (sys_imm0),
    .o_cls      (w_cls),
    .o_legal    (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cls   <= CLS_NONE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_FETCH;
        S_FETCH: if (imem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_cls <= w_cls;
          r_cnt <= (w_cls == CLS_MUL) ? MUL_LOAD : 4'd0;
          if (!w_legal)
            r_state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          else if (w_cls == CLS_ECALL || w_cls == CLS_EBREAK)
            r_state <= S_HALT;
          else
            r_state <= S_EXEC;
        end
        S_EXEC: begin
          case (r_cls)
            CLS_LOAD, CLS_STORE: r_state <= S_MEM;
            CLS_BRANCH:          r_state <= S_FETCH;
            // Counter was preloaded with MUL_CYCLES-1, so EXEC lasts MUL_CYCLES cycles.
            CLS_MUL: begin
              if (r_cnt == 4'd0) r_state <= S_WB;
              else               r_cnt   <= r_cnt - 4'd1;
            end
            default:             r_state <= S_WB;
          endcase
        end
        S_MEM:   if (dmem_ready) r_state <= (r_cls == CLS_STORE) ? S_FETCH : S_WB;
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_alu = alu_ctrl(r_cls);
  assign state = r_state;

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    alu_a_pc  = 1'b0;
    mul_busy  = 1'b0;
    halt      = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_DECODE: pc_we = !w_legal && !HALT_ON_ILLEGAL;
      S_EXEC: begin
        alu_src  = w_alu.src;
        alu_op   = w_alu.op;
        alu_a_pc = w_alu.a_pc;
        mul_busy = (r_cls == CLS_MUL);
        if (r_cls == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
        end
      end
      S_MEM: begin
        alu_src  = w_alu.src;
        alu_op   = w_alu.op;
        dmem_req = 1'b1;
        dmem_we  = (r_cls == CLS_STORE);
        pc_we    = dmem_ready && (r_cls == CLS_STORE);
      end
      S_WB: begin
        alu_src   = w_alu.src;
        alu_op    = w_alu.op;
        alu_a_pc  = w_alu.a_pc;
        reg_write = (r_cls != CLS_FENCE);
        pc_we     = 1'b1;
        wb_sel    = wb_sel_of(r_cls);
        if (r_cls == CLS_JAL)       pc_sel = PC_IMM;
        else if (r_cls == CLS_JALR) pc_sel = PC_JALR;
      end
      S_HALT: begin
        halt    = 1'b1;
        illegal = (r_cls == CLS_ILL);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: a per-cycle vector table plus hand sequences
// for multiply timing, illegal opcodes (both policies), async reset and ecall.
module tb_control_fsm;
  import rv_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       reg_write, alu_src;
    logic [1:0] alu_op, wb_sel;
    logic       alu_a_pc, dmem_req, dmem_we, mul_busy, halt, illegal;
  } out_t;

  typedef struct {
    logic       start;
    logic [6:0] op;
    logic       bt, ir, dr;
    out_t       exp;
  } vec_t;

  logic clk, rst_n, start, funct7_0, sys_imm0, branch_taken, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write, alu_src, alu_a_pc;
  logic mul_busy, halt, illegal;
  logic [1:0] pc_sel, alu_op, wb_sel;
  logic [2:0] state;
  logic n_imem_req, n_dmem_req, n_dmem_we, n_ir_we, n_pc_we, n_reg_write, n_alu_src, n_alu_a_pc;
  logic n_mul_busy, n_halt, n_illegal;
  logic [1:0] n_pc_sel, n_alu_op, n_wb_sel;
  logic [2:0] n_state;

  out_t cur;
  assign cur = {state, imem_req, ir_we, pc_we, pc_sel, reg_write, alu_src, alu_op, wb_sel,
                alu_a_pc, dmem_req, dmem_we, mul_busy, halt, illegal};

  int tests = 0;
  int errors = 0;
  vec_t vq[$];

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct7_0(funct7_0),
    .sys_imm0(sys_imm0), .branch_taken(branch_taken), .imem_req(imem_req),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_write(reg_write), .alu_src(alu_src),
    .alu_op(alu_op), .wb_sel(wb_sel), .alu_a_pc(alu_a_pc), .mul_busy(mul_busy),
    .halt(halt), .illegal(illegal), .state(state)
  );

  control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct7_0(funct7_0),
    .sys_imm0(sys_imm0), .branch_taken(branch_taken), .imem_req(n_imem_req),
    .imem_ready(imem_ready), .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .dmem_ready(dmem_ready),
    .ir_we(n_ir_we), .pc_we(n_pc_we), .pc_sel(n_pc_sel), .reg_write(n_reg_write),
    .alu_src(n_alu_src), .alu_op(n_alu_op), .wb_sel(n_wb_sel), .alu_a_pc(n_alu_a_pc),
    .mul_busy(n_mul_busy), .halt(n_halt), .illegal(n_illegal), .state(n_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] st, input logic ireq, irwe, pcwe,
                              input logic [1:0] psel, input logic rw, asrc,
                              input logic [1:0] aop, wsel,
                              input logic apc, dreq, dwe, mb, hl, il);
    return {st, ireq, irwe, pcwe, psel, rw, asrc, aop, wsel, apc, dreq, dwe, mb, hl, il};
  endfunction

  task automatic v(input logic s, input logic [6:0] op, input logic bt, ir, dr, input out_t e);
    vec_t x;
    x.start = s; x.op = op; x.bt = bt; x.ir = ir; x.dr = dr; x.exp = e;
    vq.push_back(x);
  endtask

  // FETCH with immediate ready, then DECODE.
  task automatic fd(input logic [6:0] op);
    v(0, op, 0, 1, 0, mk(S_FETCH, 1,1,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    v(0, op, 0, 0, 0, mk(S_DECODE, 0,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; opcode = '0; funct7_0 = 0; sys_imm0 = 0;
    branch_taken = 0; imem_ready = 0; dmem_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_decode(input logic [6:0] op, input logic f7, input logic imm0);
    @(negedge clk); start = 1; imem_ready = 0; opcode = op; funct7_0 = f7; sys_imm0 = imm0;
    @(negedge clk); start = 0; imem_ready = 1;
    @(negedge clk); imem_ready = 0;
  endtask

  initial begin
    int cnt;
    // idle: a stray imem_ready with no request must not move the FSM
    v(0, OP_R, 0, 1, 1, mk(S_IDLE, 0,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    v(1, OP_R, 0, 0, 0, mk(S_IDLE, 0,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    // add
    fd(OP_R);
    v(0, OP_R, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,0,2'b10,2'b00, 0,0,0,0,0,0));
    v(0, OP_R, 0, 0, 0, mk(S_WB,   0,0,1,2'b00, 1,0,2'b10,2'b00, 0,0,0,0,0,0));
    // beq taken, one fetch wait state, stray dmem_ready in FETCH
    v(0, OP_BRANCH, 0, 0, 1, mk(S_FETCH, 1,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    fd(OP_BRANCH);
    v(0, OP_BRANCH, 1, 0, 0, mk(S_EXEC, 0,0,1,2'b01, 0,0,2'b01,2'b00, 0,0,0,0,0,0));
    // lw with three data wait states
    fd(OP_LOAD);
    v(0, OP_LOAD, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,1,2'b00,2'b00, 0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      v(0, OP_LOAD, 0, 0, 0, mk(S_MEM, 0,0,0,2'b00, 0,1,2'b00,2'b00, 0,1,0,0,0,0));
    v(0, OP_LOAD, 0, 0, 1, mk(S_MEM, 0,0,0,2'b00, 0,1,2'b00,2'b00, 0,1,0,0,0,0));
    v(0, OP_LOAD, 0, 0, 0, mk(S_WB,  0,0,1,2'b00, 1,1,2'b00,2'b01, 0,0,0,0,0,0));
    // sw
    fd(OP_STORE);
    v(0, OP_STORE, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,1,2'b00,2'b00, 0,0,0,0,0,0));
    v(0, OP_STORE, 0, 0, 1, mk(S_MEM,  0,0,1,2'b00, 0,1,2'b00,2'b00, 0,1,1,0,0,0));
    // jal
    fd(OP_JAL);
    v(0, OP_JAL, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    v(0, OP_JAL, 0, 0, 0, mk(S_WB,   0,0,1,2'b01, 1,0,2'b00,2'b10, 0,0,0,0,0,0));
    // jalr
    fd(OP_JALR);
    v(0, OP_JALR, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,1,2'b00,2'b00, 0,0,0,0,0,0));
    v(0, OP_JALR, 0, 0, 0, mk(S_WB,   0,0,1,2'b10, 1,1,2'b00,2'b10, 0,0,0,0,0,0));
    // lui
    fd(OP_LUI);
    v(0, OP_LUI, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    v(0, OP_LUI, 0, 0, 0, mk(S_WB,   0,0,1,2'b00, 1,0,2'b00,2'b11, 0,0,0,0,0,0));
    // auipc
    fd(OP_AUIPC);
    v(0, OP_AUIPC, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,1,2'b00,2'b00, 1,0,0,0,0,0));
    v(0, OP_AUIPC, 0, 0, 0, mk(S_WB,   0,0,1,2'b00, 1,1,2'b00,2'b00, 1,0,0,0,0,0));
    // fence: PC advances, no register write
    fd(OP_FENCE);
    v(0, OP_FENCE, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    v(0, OP_FENCE, 0, 0, 0, mk(S_WB,   0,0,1,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));
    // addi
    fd(OP_I);
    v(0, OP_I, 0, 0, 0, mk(S_EXEC, 0,0,0,2'b00, 0,1,2'b11,2'b00, 0,0,0,0,0,0));
    v(0, OP_I, 0, 0, 0, mk(S_WB,   0,0,1,2'b00, 1,1,2'b11,2'b00, 0,0,0,0,0,0));
    // beq not taken
    fd(OP_BRANCH);
    v(0, OP_BRANCH, 0, 0, 0, mk(S_EXEC, 0,0,1,2'b00, 0,0,2'b01,2'b00, 0,0,0,0,0,0));
    v(0, OP_BRANCH, 0, 0, 0, mk(S_FETCH, 1,0,0,2'b00, 0,0,2'b00,2'b00, 0,0,0,0,0,0));

    do_reset();
    foreach (vq[i]) begin
      @(negedge clk);
      start = vq[i].start; opcode = vq[i].op; funct7_0 = 0; sys_imm0 = 0;
      branch_taken = vq[i].bt; imem_ready = vq[i].ir; dmem_ready = vq[i].dr;
      #1;
      tests++;
      if (cur !== vq[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", i, cur, vq[i].exp);
      end
    end

    // multiply: mul_busy for exactly 4 EXEC cycles, then WB
    do_reset();
    go_decode(OP_R, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (state == S_EXEC && mul_busy) cnt++;
      else break;
    end
    chk("mul_busy_cycles", cnt, 4);
    chk("mul_then_wb", {29'd0, state}, {29'd0, S_WB});
    chk("mul_wb_reg_write", {31'd0, reg_write}, 1);

    // illegal opcode under both policies
    do_reset();
    go_decode(7'b1111111, 1'b0, 1'b0);
    #1;
    chk("nop_decode_pc_we", {31'd0, n_pc_we}, 1);
    chk("nop_decode_pc_sel", {30'd0, n_pc_sel}, 0);
    chk("halt_decode_pc_we", {31'd0, pc_we}, 0);
    @(negedge clk); #1;
    chk("ill_state_halt", {29'd0, state}, {29'd0, S_HALT});
    chk("ill_flag", {30'd0, halt, illegal}, 3);
    chk("nop_back_to_fetch", {29'd0, n_state}, {29'd0, S_FETCH});
    chk("nop_no_illegal", {31'd0, n_illegal}, 0);
    start = 1; imem_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("halt_absorbing", {29'd0, state}, {29'd0, S_HALT});
    chk("halt_no_enables", {28'd0, imem_req, ir_we, pc_we, reg_write}, 0);
    start = 0; imem_ready = 0;

    // asynchronous reset while waiting on data memory
    do_reset();
    go_decode(OP_LOAD, 1'b0, 1'b0);
    dmem_ready = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("mem_wait_req", {31'd0, dmem_req}, 1);
    rst_n = 0;
    #1;
    chk("arst_dmem_req", {31'd0, dmem_req}, 0);
    chk("arst_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("arst_all_outputs", {12'd0, cur}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    chk("idle_without_start", {29'd0, state}, {29'd0, S_IDLE});

    // ecall halts without flagging illegal
    go_decode(OP_SYSTEM, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("ecall_halt", {29'd0, state}, {29'd0, S_HALT});
    chk("ecall_flags", {30'd0, halt, illegal}, 2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
